// File: rtl/err_injector_param.sv
// Channel error injector: corrupts valid words with an XOR mask in periodic, burst or LFSR-random mode.
// Optional saturating injected-error counter on o_err_cnt when ERR_INJECTOR_STATS_EN is defined.
module err_injector_param #(
    parameter int                W      = 2,
    parameter int                CNT_W  = 12,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [CNT_W-1:0]  i_first_err,
    input  logic [CNT_W-1:0]  i_err_rate,
    input  logic [CNT_W-1:0]  i_burst_len,
    input  logic [LFSR_W-1:0] i_threshold,
    input  logic [W-1:0]      i_err_mask,
    input  logic              i_vld,
    input  logic [W-1:0]      i_word,
    output logic              o_vld,
    output logic [W-1:0]      o_word,
    output logic              o_err,
    output logic [31:0]       o_err_cnt
);

    typedef enum logic [1:0] {WAIT_FIRST, GAP, BURST, DONE} state_t;

    localparam logic [1:0] MODE_PERIODIC = 2'd0;
    localparam logic [1:0] MODE_BURST    = 2'd1;
    localparam logic [1:0] MODE_RANDOM   = 2'd2;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Fibonacci feedback mask in right-shift form: tap t maps to bit (LFSR_W - t).
    function automatic logic [LFSR_W-1:0] tap_mask();
        int taps [4];
        logic [LFSR_W-1:0] m;
        case (LFSR_W)
            8:       taps = '{8, 6, 5, 4};
            16:      taps = '{16, 14, 13, 11};
            24:      taps = '{24, 23, 22, 17};
            32:      taps = '{32, 22, 2, 1};
            default: taps = '{LFSR_W, LFSR_W - 1, 0, 0};
        endcase
        m = '0;
        for (int i = 0; i < 4; i++)
            if (taps[i] != 0)
                m = m | (LFSR_W'(1) << (LFSR_W - taps[i]));
        return m;
    endfunction

    localparam logic [LFSR_W-1:0] TAP_MASK = tap_mask();

    state_t             state, state_n;
    logic [CNT_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   per, per_n;
    logic [CNT_W-1:0]   blen, blen_n;
    logic [LFSR_W-1:0]  lfsr, lfsr_next;
    logic [CNT_W-1:0]   eff_len;
    logic [CNT_W-1:0]   blen_inc;
    logic               fsm_adv;
    logic               fsm_hit;
    logic               hit;
    state_t             start_next;

    assign eff_len   = (i_burst_len == '0) ? ONE : i_burst_len;
    assign blen_inc  = blen + ONE;
    assign fsm_adv   = i_enable && i_vld && ((i_mode == MODE_PERIODIC) || (i_mode == MODE_BURST));
    assign lfsr_next = {^(lfsr & TAP_MASK), lfsr[LFSR_W-1:1]};

    always_comb begin
        if ((i_mode == MODE_BURST) && (eff_len > ONE))
            start_next = BURST;
        else if (i_err_rate == '0)
            start_next = DONE;
        else
            start_next = GAP;
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        per_n   = per;
        blen_n  = blen;
        fsm_hit = 1'b0;
        if (fsm_adv) begin
            case (state)
                WAIT_FIRST: begin
                    if (idx == i_first_err) begin
                        fsm_hit = 1'b1;
                        per_n   = ONE;
                        blen_n  = ONE;
                        state_n = start_next;
                    end else begin
                        idx_n = idx + ONE;
                    end
                end
                GAP: begin
                    if (per == i_err_rate) begin
                        fsm_hit = 1'b1;
                        per_n   = ONE;
                        blen_n  = ONE;
                        state_n = start_next;
                    end else begin
                        per_n = per + ONE;
                    end
                end
                BURST: begin
                    fsm_hit = 1'b1;
                    if ((i_err_rate != '0) && (per == i_err_rate)) begin
                        // A new event starts inside the burst; long bursts become continuous.
                        per_n   = ONE;
                        blen_n  = ONE;
                        state_n = start_next;
                    end else begin
                        per_n  = per + ONE;
                        blen_n = blen_inc;
                        if (blen_inc >= eff_len)
                            state_n = (i_err_rate == '0) ? DONE : GAP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hit = 1'b0;
        if (i_enable && i_vld) begin
            case (i_mode)
                MODE_PERIODIC, MODE_BURST: hit = fsm_hit;
                MODE_RANDOM:               hit = (lfsr < i_threshold);
                default:                   hit = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_FIRST;
            idx   <= '0;
            per   <= '0;
            blen  <= '0;
            lfsr  <= SEED;
        end else if (!i_enable) begin
            state <= WAIT_FIRST;
            idx   <= '0;
            per   <= '0;
            blen  <= '0;
            lfsr  <= SEED;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            per   <= per_n;
            blen  <= blen_n;
            if (i_vld)
                lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_vld  <= 1'b0;
            o_word <= '0;
            o_err  <= 1'b0;
        end else begin
            o_vld <= i_vld;
            o_err <= hit;
            if (i_vld)
                o_word <= i_word ^ (hit ? i_err_mask : '0);
        end
    end

`ifdef ERR_INJECTOR_STATS_EN
    logic [31:0] err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= '0;
        else if (o_vld && o_err && (err_cnt != 32'hFFFF_FFFF))
            err_cnt <= err_cnt + 32'd1;
    end

    assign o_err_cnt = err_cnt;
`else
    assign o_err_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_err_injector_param.sv
// Randomised bench for err_injector_param against an index-arithmetic reference model.
// Expects o_err_cnt to track pulses when ERR_INJECTOR_STATS_EN is defined, else to stay 0.
module tb_err_injector_param;

    localparam int W = 2;
    localparam int CNT_W = 12;
    localparam int LFSR_W = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_enable;
    logic [1:0]        i_mode;
    logic [CNT_W-1:0]  i_first_err;
    logic [CNT_W-1:0]  i_err_rate;
    logic [CNT_W-1:0]  i_burst_len;
    logic [LFSR_W-1:0] i_threshold;
    logic [W-1:0]      i_err_mask;
    logic              i_vld;
    logic [W-1:0]      i_word;
    logic              o_vld;
    logic [W-1:0]      o_word;
    logic              o_err;
    logic [31:0]       o_err_cnt;

    err_injector_param #(.W(W), .CNT_W(CNT_W), .LFSR_W(LFSR_W), .SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_mode(i_mode),
        .i_first_err(i_first_err), .i_err_rate(i_err_rate), .i_burst_len(i_burst_len),
        .i_threshold(i_threshold), .i_err_mask(i_err_mask), .i_vld(i_vld), .i_word(i_word),
        .o_vld(o_vld), .o_word(o_word), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          k;
    logic [15:0] m_lfsr;
    logic        exp_vld;
    logic [W-1:0] exp_word;
    logic        exp_err;
    longint      exp_cnt;
    int          obs_hits;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11];
        return {fb, l[15:1]};
    endfunction

    // Word k (0-based valid index since restart) is hit when it lies within eff_len
    // words after an event start f, f+rate, f+2*rate, ... (only f when rate is 0).
    function automatic bit ref_hit(input int kk);
        int f, r, len, d;
        case (i_mode)
            2'd0, 2'd1: begin
                f   = int'(i_first_err);
                r   = int'(i_err_rate);
                len = (i_mode == 2'd1 && i_burst_len != 0) ? int'(i_burst_len) : 1;
                d   = kk - f;
                if (d < 0)  return 1'b0;
                if (r == 0) return d < len;
                return (d % r) < len;
            end
            2'd2:    return m_lfsr < i_threshold;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        k        = 0;
        m_lfsr   = SEED;
        exp_vld  = 1'b0;
        exp_word = '0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] w);
        bit hit;
        bit cnt_inc;
        i_vld   = v;
        i_word  = w;
        cnt_inc = exp_vld && exp_err;
        hit     = i_enable && v && ref_hit(k);
        exp_vld = v;
        exp_err = hit;
        if (v) exp_word = w ^ (hit ? i_err_mask : '0);
        if (!i_enable) begin
            k      = 0;
            m_lfsr = SEED;
        end else if (v) begin
            k++;
            m_lfsr = lfsr_step(m_lfsr);
        end
        @(posedge clk);
        #1;
        if (cnt_inc && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
        check("vld", 32'(o_vld), 32'(exp_vld));
        check("word", 32'(o_word), 32'(exp_word));
        check("err", 32'(o_err), 32'(exp_err));
`ifdef ERR_INJECTOR_STATS_EN
        check("err_cnt", o_err_cnt, exp_cnt[31:0]);
`else
        check("err_cnt", o_err_cnt, 32'd0);
`endif
        if (o_vld && o_err) obs_hits++;
    endtask

    task automatic configure(input logic [1:0] mode, input int f, input int rate, input int len,
                             input logic [15:0] thr, input logic [W-1:0] mask);
        i_mode      = mode;
        i_first_err = CNT_W'(f);
        i_err_rate  = CNT_W'(rate);
        i_burst_len = CNT_W'(len);
        i_threshold = thr;
        i_err_mask  = mask;
        i_enable    = 1'b0;
        step(1'b0, '0);
        i_enable    = 1'b1;
        obs_hits    = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        i_enable = 1'b0; i_mode = '0; i_first_err = '0; i_err_rate = '0; i_burst_len = '0;
        i_threshold = '0; i_err_mask = '0; i_vld = 1'b0; i_word = '0;
        model_reset();
        obs_hits = 0;
        #3;
        check("rst_vld", 32'(o_vld), 32'd0);
        check("rst_word", 32'(o_word), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_cnt", o_err_cnt, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        configure(2'd0, 3, 5, 0, '0, 2'b01);
        repeat (20) step(1'b1, 2'b00);
        check("m0_hits", 32'(obs_hits), 32'd4);

        configure(2'd1, 2, 8, 3, '0, 2'b11);
        repeat (20) step(1'b1, 2'b00);
        check("m1_hits", 32'(obs_hits), 32'd8);

        configure(2'd0, 1, 0, 0, '0, 2'b10);
        repeat (100) step(1'b1, W'($urandom));
        check("once_hits", 32'(obs_hits), 32'd1);
        i_enable = 1'b0;
        step(1'b1, W'($urandom));
        i_enable = 1'b1;
        repeat (5) step(1'b1, W'($urandom));
        check("reenable_hits", 32'(obs_hits), 32'd2);

        configure(2'd0, 2, 2, 0, '0, 2'b11);
        repeat (7) begin
            step(1'b1, W'($urandom));
            step(1'b0, W'($urandom));
            step(1'b0, W'($urandom));
        end
        check("gap_hits", 32'(obs_hits), 32'd3);

        configure(2'd2, 0, 0, 0, 16'h0000, 2'b11);
        repeat (1000) step(1'b1, W'($urandom));
        check("rnd_zero", 32'(obs_hits), 32'd0);
        configure(2'd2, 0, 0, 0, 16'h8000, 2'b01);
        repeat (1000) step(1'b1, W'($urandom));
        check("rnd_range", 32'(obs_hits >= 450 && obs_hits <= 550), 32'd1);

        for (int s = 0; s < 40; s++) begin
            configure(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                      16'($urandom), W'($urandom));
            repeat (80) step(1'($urandom_range(0, 3) != 0), W'($urandom));
        end

        configure(2'd1, 0, 0, 6, '0, 2'b11);
        repeat (3) step(1'b1, 2'b00);
        reset_n = 1'b0;
        #1;
        check("async_vld", 32'(o_vld), 32'd0);
        check("async_word", 32'(o_word), 32'd0);
        check("async_err", 32'(o_err), 32'd0);
        check("async_cnt", o_err_cnt, 32'd0);
        model_reset();
        i_vld = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        i_mode = 2'd0;
        obs_hits = 0;
        step(1'b1, 2'b00);
        check("post_rst_first", 32'(o_err), 32'd1);
        configure(2'd1, 1, 4, 2, '0, 2'b01);
        obs_hits = obs_hits + 1;
        repeat (30) step(1'($urandom_range(0, 1)), W'($urandom));
        step(1'b0, '0);
`ifdef ERR_INJECTOR_STATS_EN
        check("cnt_total", o_err_cnt, 32'(obs_hits));
`else
        check("cnt_total", o_err_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
